// File: rtl/vram_arb.sv
// Display/host arbiter for the single-port 6 KB display RAM.
// Display has priority; a starve counter bounds how long the host can wait.
module vram_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        disp_req,
  input  logic [12:0] disp_addr,
  output logic        disp_ack,
  output logic        disp_rvld,
  output logic [7:0]  disp_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [12:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic        host_rvld,
  output logic [7:0]  host_rdata,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_di,
  input  logic [7:0]  ram_do
);

  localparam logic [12:0] ADDR_LIM = 13'h1800;
  localparam logic [3:0]  SMAX     = 4'(STARVE_MAX);

  typedef struct packed {
    logic vld;
    logic host;
    logic inr;
  } tag_t;

  logic        g_disp;
  logic        g_host;
  logic        disp_inr;
  logic        host_inr;

  logic [3:0]  starve_q, starve_d;
  tag_t        t1_q, t1_d;
  tag_t        t2_q, t2_d;
  logic        ram_ce_q, ram_ce_d;
  logic        ram_we_q, ram_we_d;
  logic [12:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_di_q, ram_di_d;
  logic        disp_rvld_q, disp_rvld_d;
  logic        host_rvld_q, host_rvld_d;
  logic [7:0]  disp_rdata_q, disp_rdata_d;
  logic [7:0]  host_rdata_q, host_rdata_d;

  always_comb begin
    g_disp   = disp_req && (starve_q < SMAX);
    g_host   = host_req && !g_disp;
    disp_inr = disp_addr < ADDR_LIM;
    host_inr = host_addr < ADDR_LIM;
  end

  assign disp_ack = g_disp;
  assign host_ack = g_host;

  // Counts host-pending cycles lost to the display.
  always_comb begin
    starve_d = starve_q;
    if (!host_req || g_host) begin
      starve_d = '0;
    end else if (g_disp && (starve_q < SMAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    ram_ce_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    t1_d       = '0;
    unique case (1'b1)
      g_disp: begin
        ram_addr_d = disp_addr;
        ram_ce_d   = disp_inr;
        t1_d.vld   = 1'b1;
        t1_d.host  = 1'b0;
        t1_d.inr   = disp_inr;
      end
      g_host: begin
        ram_addr_d = host_addr;
        ram_di_d   = host_wdata;
        ram_we_d   = host_we;
        ram_ce_d   = host_inr;
        t1_d.vld   = !host_we;
        t1_d.host  = 1'b1;
        t1_d.inr   = host_inr;
      end
      default: ;
    endcase
  end

  // Tag stage 2 lines up with ram_do for the read it tracks.
  always_comb begin
    t2_d         = t1_q;
    disp_rvld_d  = t2_q.vld && !t2_q.host;
    host_rvld_d  = t2_q.vld && t2_q.host;
    disp_rdata_d = disp_rdata_q;
    host_rdata_d = host_rdata_q;
    if (disp_rvld_d) begin
      disp_rdata_d = t2_q.inr ? ram_do : 8'h00;
    end
    if (host_rvld_d) begin
      host_rdata_d = t2_q.inr ? ram_do : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      starve_q     <= '0;
      t1_q         <= '0;
      t2_q         <= '0;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_di_q     <= '0;
      disp_rvld_q  <= 1'b0;
      host_rvld_q  <= 1'b0;
      disp_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      starve_q     <= starve_d;
      t1_q         <= t1_d;
      t2_q         <= t2_d;
      ram_ce_q     <= ram_ce_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_di_q     <= ram_di_d;
      disp_rvld_q  <= disp_rvld_d;
      host_rvld_q  <= host_rvld_d;
      disp_rdata_q <= disp_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign ram_ce     = ram_ce_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_di     = ram_di_q;
  assign disp_rvld  = disp_rvld_q;
  assign host_rvld  = host_rvld_q;
  assign disp_rdata = disp_rdata_q;
  assign host_rdata = host_rdata_q;

endmodule
